// File: rtl/uart_baud_ctrl.sv
// rtl/uart_baud_ctrl.sv - UART baud-rate controller: divisor register, divide counter, s_tick/bit_tick
// Optional feature macro: UART_BAUD_MINCHK_EN (adds cfg_err and a MIN_DIV lower-bound check
// on accepted divisor requests). With the macro undefined every accepted divisor is used.
module uart_baud_ctrl #(
    parameter int BITS        = 11,
    parameter int DEFAULT_DIV = 650,
    parameter int OVS         = 16
`ifdef UART_BAUD_MINCHK_EN
    ,
    parameter int MIN_DIV     = 1
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            cfg_valid,
    input  logic [BITS-1:0] cfg_div,
    output logic            cfg_ready,
`ifdef UART_BAUD_MINCHK_EN
    output logic            cfg_err,
`endif
    output logic [BITS-1:0] cur_div,
    output logic            s_tick,
    output logic            bit_tick,
    output logic            busy
);

    // Oversample counter width; OVS >= 2 keeps this at least one bit.
    localparam int OW = $clog2(OVS);

    localparam logic [BITS-1:0] DEF_DIV  = BITS'(DEFAULT_DIV);
    localparam logic [OW-1:0]   OVS_LAST = OW'(OVS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]      state_q,    state_d;
    logic [BITS-1:0] cnt_q,      cnt_d;
    logic [OW-1:0]   ovs_q,      ovs_d;
    logic [BITS-1:0] cur_div_q,  cur_div_d;
    logic [BITS-1:0] pend_div_q, pend_div_d;
    logic            s_tick_q,   s_tick_d;
    logic            bit_tick_q, bit_tick_d;

    logic            accept;
    logic            accept_ok;
    logic [BITS-1:0] cmp_div;
    logic            boundary;
    logic            ovs_last;

`ifdef UART_BAUD_MINCHK_EN
    localparam logic [BITS-1:0] MIN_DIV_V = BITS'(MIN_DIV);

    logic cfg_err_q, cfg_err_d;
    logic range_bad;

    // A request below the legal minimum is consumed but otherwise ignored.
    assign range_bad = (cfg_div < MIN_DIV_V);
    assign accept_ok = accept & ~range_bad;
    assign cfg_err_d = accept & range_bad;
    assign cfg_err   = cfg_err_q;
`else
    assign accept_ok = accept;
`endif

    // A new request can only be taken when no earlier one is still waiting for its boundary.
    assign cfg_ready = (state_q != ST_PEND);
    assign busy      = (state_q == ST_PEND);
    assign accept    = cfg_valid & cfg_ready;

    // In IDLE a request that arrives with enable already takes part in edge 0.
    assign cmp_div  = ((state_q == ST_IDLE) && accept_ok) ? cfg_div : cur_div_q;
    assign boundary = (cnt_q == cmp_div);
    assign ovs_last = (ovs_q == OVS_LAST);

    assign cur_div  = cur_div_q;
    assign s_tick   = s_tick_q;
    assign bit_tick = bit_tick_q;

    // Next-state logic: counting, tick generation and boundary-aligned divisor hand-over.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovs_d      = ovs_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        s_tick_d   = 1'b0;
        bit_tick_d = 1'b0;

        if (!enable) begin
            // Disabled: park the counters; a waiting divisor is committed rather than lost.
            state_d = ST_IDLE;
            cnt_d   = '0;
            ovs_d   = '0;
            if (state_q == ST_PEND) begin
                cur_div_d = pend_div_q;
            end else if (accept_ok) begin
                cur_div_d = cfg_div;
            end
        end else begin
            // Shared divide/oversample counting for every enabled state.
            if (boundary) begin
                cnt_d      = '0;
                s_tick_d   = 1'b1;
                bit_tick_d = ovs_last;
                ovs_d      = ovs_last ? '0 : ovs_q + OW'(1);
            end else begin
                cnt_d = cnt_q + BITS'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept_ok) begin
                        cur_div_d = cfg_div;
                    end
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    // Even on a boundary edge the running period finishes with the old divisor.
                    if (accept_ok) begin
                        pend_div_d = cfg_div;
                        state_d    = ST_PEND;
                    end
                end
                ST_PEND: begin
                    // Swap on the boundary so the new period starts from a clean cnt and ovs.
                    if (boundary) begin
                        cur_div_d = pend_div_q;
                        ovs_d     = '0;
                        state_d   = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ovs_d   = '0;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ovs_q      <= '0;
            cur_div_q  <= DEF_DIV;
            pend_div_q <= DEF_DIV;
            s_tick_q   <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovs_q      <= ovs_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            s_tick_q   <= s_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

`ifdef UART_BAUD_MINCHK_EN
    // One-cycle error pulse for a rejected divisor request.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb/tb_uart_baud_ctrl.sv - directed self-checking bench for uart_baud_ctrl
module tb_uart_baud_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic [10:0] cfg_div;
    logic        cfg_ready;
    logic [10:0] cur_div;
    logic        s_tick;
    logic        bit_tick;
    logic        busy;
`ifdef UART_BAUD_MINCHK_EN
    logic        cfg_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    uart_baud_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
`ifdef UART_BAUD_MINCHK_EN
        .cfg_err   (cfg_err),
`endif
        .cur_div   (cur_div),
        .s_tick    (s_tick),
        .bit_tick  (bit_tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_s;

        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;

        // Reset held three cycles
        step(); step(); step();
        chk("rst_cur_div",   cur_div,   650);
        chk("rst_s_tick",    s_tick,    0);
        chk("rst_bit_tick",  bit_tick,  0);
        chk("rst_busy",      busy,      0);
        chk("rst_cfg_ready", cfg_ready, 1);

        // IDLE write of D=3, then enable
        reset     = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = 11'd3;
        step();
        cfg_valid = 1'b0;
        chk("idle_cur_div", cur_div, 3);
        chk("idle_s_tick",  s_tick,  0);
        enable = 1'b1;
        for (int k = 0; k < 128; k++) begin
            step();
            chk("d3_s_tick",   s_tick,   (k % 4) == 3);
            chk("d3_bit_tick", bit_tick, (k % 64) == 63);
        end

        // Request D=7 while cnt=1
        step();
        chk("pre_req_s_tick", s_tick, 0);
        cfg_valid = 1'b1;
        cfg_div   = 11'd7;
        step();
        cfg_valid = 1'b0;
        chk("pend_busy",      busy,      1);
        chk("pend_cfg_ready", cfg_ready, 0);
        chk("pend_cur_div",   cur_div,   3);
        chk("pend_s_tick0",   s_tick,    0);
        step();
        chk("pend_s_tick1",   s_tick,    0);
        step();
        chk("swap_s_tick",    s_tick,    1);
        chk("swap_bit_tick",  bit_tick,  0);
        chk("swap_cur_div",   cur_div,   7);
        chk("swap_busy",      busy,      0);
        chk("swap_cfg_ready", cfg_ready, 1);
        for (int j = 1; j <= 128; j++) begin
            step();
            chk("d7_s_tick",   s_tick,   (j % 8) == 0);
            chk("d7_bit_tick", bit_tick, j == 128);
        end

        // PEND then enable falls: pending divisor committed, ticks stop
        cfg_valid = 1'b1;
        cfg_div   = 11'd5;
        step();
        cfg_valid = 1'b0;
        chk("p5_busy", busy, 1);
        enable = 1'b0;
        step();
        chk("dis_busy",      busy,      0);
        chk("dis_cfg_ready", cfg_ready, 1);
        chk("dis_cur_div",   cur_div,   5);
        chk("dis_s_tick",    s_tick,    0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("off_s_tick",   s_tick,   0);
            chk("off_bit_tick", bit_tick, 0);
        end
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("d5_s_tick",   s_tick,   (k % 6) == 5);
            chk("d5_bit_tick", bit_tick, 0);
        end

        // D=0 accepted on the same edge enable rises in IDLE
        enable = 1'b0;
        step();
        cfg_valid = 1'b1;
        cfg_div   = 11'd0;
        enable    = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("d0_first_s_tick", s_tick,   1);
        chk("d0_cur_div",      cur_div,  0);
        chk("d0_first_bit",    bit_tick, 0);
        for (int k = 1; k < 48; k++) begin
            step();
            chk("d0_s_tick",   s_tick,   1);
            chk("d0_bit_tick", bit_tick, (k % 16) == 15);
        end

        // Accept exactly on a boundary: old divisor finishes, new one at next boundary
        cfg_valid = 1'b1;
        cfg_div   = 11'd3;
        step();
        cfg_valid = 1'b0;
        chk("bnd_s_tick",  s_tick,  1);
        chk("bnd_busy",    busy,    1);
        chk("bnd_cur_div", cur_div, 0);
        step();
        chk("bnd2_cur_div", cur_div, 3);
        chk("bnd2_busy",    busy,    0);
        chk("bnd2_s_tick",  s_tick,  1);
        for (int j = 1; j <= 8; j++) begin
            step();
            chk("bd3_s_tick", s_tick, (j % 4) == 0);
        end

        // Request D=0 (below MIN_DIV when the range check is built in)
        cfg_valid = 1'b1;
        cfg_div   = 11'd0;
        step();
        cfg_valid = 1'b0;
`ifdef UART_BAUD_MINCHK_EN
        chk("min_cfg_err", cfg_err, 1);
        chk("min_busy",    busy,    0);
`else
        chk("z_busy", busy, 1);
`endif
        for (int m = 1; m <= 12; m++) begin
            step();
`ifdef UART_BAUD_MINCHK_EN
            exp_s = ((m % 4) == 3);
            if (m == 1) chk("min_cfg_err_clr", cfg_err, 0);
`else
            exp_s = (m >= 3);
`endif
            chk("z_s_tick", s_tick, exp_s);
        end
`ifdef UART_BAUD_MINCHK_EN
        chk("min_cur_div", cur_div, 3);
`else
        chk("z_cur_div", cur_div, 0);
`endif

        // Reset while a request is pending
        cfg_valid = 1'b1;
        cfg_div   = 11'd9;
        step();
        cfg_valid = 1'b0;
        chk("rp_busy", busy, 1);
        reset = 1'b1;
        step();
        chk("rp_cur_div",   cur_div,   650);
        chk("rp_busy2",     busy,      0);
        chk("rp_cfg_ready", cfg_ready, 1);
        chk("rp_s_tick",    s_tick,    0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
